// File: rtl/game_pkg.sv
// Shared types and constants for the memory-sequence game controller.
// Holds the FSM state encoding, sequence length limit and LFSR constants.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAdd,
    StShowOn,
    StShowOff,
    StWaitIn,
    StWin,
    StLose
  } game_state_e;

  localparam int unsigned MAX_LEN   = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [3:0] onehot2(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every cycle out of reset so the
// generated sequence depends on how long the player takes.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/game_seq_ctrl.sv
// Memory-sequence game controller: appends a random lamp to an external register
// file each round, plays the sequence back, then checks the player's echo.
module game_seq_ctrl
  import game_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES    = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 125_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [3:0] btn,
  output logic       rf_we,
  output logic [3:0] rf_wdata,
  output logic [3:0] rf_wsel,
  output logic [3:0] rf_rsel,
  input  logic [3:0] rf_rdata,
  output logic [3:0] lamp,
  output logic [4:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int unsigned MaxCycles =
      (TIMEOUT_CYCLES > SHOW_CYCLES) ? TIMEOUT_CYCLES : SHOW_CYCLES;
  localparam int unsigned TimerW = $clog2(MaxCycles + 1);
  // Timers count down to zero, so a load of N-1 gives exactly N cycles in a state.
  localparam logic [TimerW-1:0] ShowLoad    = TimerW'(SHOW_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLoad = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]        MaxLen      = 5'(MAX_LEN);

  game_state_e       state_q;
  logic [4:0]        len_q;
  logic [3:0]        idx_q;
  logic [TimerW-1:0] timer_q;
  logic [4:0]        level_q;
  logic [15:0]       lfsr;
  logic              unused_lfsr_hi;
  logic              last_idx;
  logic              btn_match;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:2];
  assign last_idx       = ({1'b0, idx_q} == (len_q - 5'd1));
  // A non-one-hot btn can never equal a stored code, so it always loses.
  assign btn_match      = (btn == rf_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      level_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StWin, StLose: begin
          if (start) begin
            len_q   <= '0;
            idx_q   <= '0;
            level_q <= '0;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          len_q   <= (len_q == MaxLen) ? len_q : len_q + 5'd1;
          idx_q   <= '0;
          timer_q <= ShowLoad;
          state_q <= StShowOn;
        end
        StShowOn: begin
          if (timer_q == '0) begin
            timer_q <= ShowLoad;
            state_q <= StShowOff;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        StShowOff: begin
          if (timer_q == '0) begin
            if (last_idx) begin
              idx_q   <= '0;
              timer_q <= TimeoutLoad;
              state_q <= StWaitIn;
            end else begin
              idx_q   <= idx_q + 4'd1;
              timer_q <= ShowLoad;
              state_q <= StShowOn;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        StWaitIn: begin
          if (btn_valid) begin
            if (!btn_match) begin
              state_q <= StLose;
            end else if (last_idx) begin
              level_q <= len_q;
              state_q <= (len_q == MaxLen) ? StWin : StAdd;
            end else begin
              idx_q   <= idx_q + 4'd1;
              timer_q <= TimeoutLoad;
            end
          end else if (timer_q == '0) begin
            state_q <= StLose;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rf_we    = (state_q == StAdd);
    rf_wsel  = rf_we ? len_q[3:0] : 4'd0;
    rf_wdata = rf_we ? onehot2(lfsr[1:0]) : 4'd0;
    rf_rsel  = idx_q;
    lamp     = (state_q == StShowOn) ? rf_rdata : 4'd0;
    busy     = (state_q == StAdd) || (state_q == StShowOn) ||
               (state_q == StShowOff) || (state_q == StWaitIn);
    win      = (state_q == StWin);
    lose     = (state_q == StLose);
  end

  assign level = level_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Self-checking bench for game_seq_ctrl with a behavioural register file attached;
// register-file writes are predicted into a queue and matched as the DUT issues them.
`timescale 1ns/1ps
module tb_game_seq_ctrl;

  localparam int unsigned ShowCycles    = 2;
  localparam int unsigned TimeoutCycles = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       btn_valid;
  logic [3:0] btn;
  logic       rf_we;
  logic [3:0] rf_wdata;
  logic [3:0] rf_wsel;
  logic [3:0] rf_rsel;
  logic [3:0] rf_rdata;
  logic [3:0] lamp;
  logic [4:0] level;
  logic       busy;
  logic       win;
  logic       lose;

  game_seq_ctrl #(
    .SHOW_CYCLES    (ShowCycles),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .btn_valid (btn_valid),
    .btn       (btn),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata),
    .rf_wsel   (rf_wsel),
    .rf_rsel   (rf_rsel),
    .rf_rdata  (rf_rdata),
    .lamp      (lamp),
    .level     (level),
    .busy      (busy),
    .win       (win),
    .lose      (lose)
  );

  always #5 clk = ~clk;

  logic [3:0] rf_mem [16];
  always @(posedge clk) if (rf_we) rf_mem[rf_wsel] <= rf_wdata;
  assign rf_rdata = rf_mem[rf_rsel];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  logic [15:0] lfsr_m;
  always @(posedge clk) lfsr_m <= rst ? 16'hACE1 : lfsr_next(lfsr_m);

  typedef struct packed {
    logic [3:0] wsel;
    logic [3:0] wdata;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [3:0] seq [16];
  int         len_m;
  logic [15:0] wr_mask;
  bit         mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rf_we_unexpected: got write idx %0d data %b, expected no write",
                   rf_wsel, rf_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("rf_wsel", rf_wsel, mon_e.wsel);
          check("rf_wdata", rf_wdata, mon_e.wdata);
          wr_mask[rf_wsel] = 1'b1;
        end
      end else begin
        check("rf_w_idle", {rf_we, rf_wsel, rf_wdata}, 9'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; btn_valid = 1'b0; btn = 4'd0;
    step();
    step();
    rst = 1'b0;
    len_m = 0;
    exp_q.delete();
    wr_mask = '0;
  endtask

  // Called one cycle before the DUT enters ADD: predicts the appended code.
  task automatic expect_add();
    logic [15:0] nxt;
    logic [3:0]  code;
    nxt  = lfsr_next(lfsr_m);
    code = 4'b0001 << nxt[1:0];
    seq[len_m] = code;
    exp_q.push_back('{wsel: len_m[3:0], wdata: code});
    len_m++;
  endtask

  task automatic start_game();
    start = 1'b1;
    len_m = 0;
    expect_add();
    step();
    start = 1'b0;
    check("busy_add", busy, 1'b1);
  endtask

  // Starts at the ADD cycle, ends on the first WAIT_IN cycle.
  // inject: 1 = start during SHOW_OFF, 2 = bad btn_valid during SHOW_ON.
  task automatic play_round(input int inject);
    step();
    for (int i = 0; i < len_m; i++) begin
      for (int c = 0; c < 2; c++) begin
        check("lamp_on", lamp, seq[i]);
        if (inject == 2 && i == 0 && c == 0) begin btn_valid = 1'b1; btn = 4'b0011; end
        step();
        btn_valid = 1'b0; btn = 4'd0;
      end
      for (int c = 0; c < 2; c++) begin
        check("lamp_off", lamp, 4'd0);
        if (inject == 1 && i == 0 && c == 0) start = 1'b1;
        step();
        start = 1'b0;
      end
    end
    check("busy_wait", busy, 1'b1);
    check("lamp_wait", lamp, 4'd0);
    check("lose_wait", lose, 1'b0);
  endtask

  task automatic press(input logic [3:0] b);
    btn = b; btn_valid = 1'b1;
    step();
    btn = 4'd0; btn_valid = 1'b0;
  endtask

  task automatic echo_round();
    int n;
    n = len_m;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1 && n < 16) expect_add();
      press(seq[i]);
    end
    check("level_round", level, n);
    check("busy_round", busy, (n < 16) ? 1'b1 : 1'b0);
    check("win_round", win, (n == 16) ? 1'b1 : 1'b0);
  endtask

  function automatic logic [3:0] rot(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  typedef struct {
    int         idle;
    bit         press;
    int         kind;       // 0 correct, 1 wrong one-hot, 2 4'b0011, 3 4'b0000
    bit         with_start;
    bit         exp_lose;
    logic [4:0] exp_level;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] b;

    vecs[0] = '{0,  1'b1, 0, 1'b0, 1'b0, 5'd1};
    vecs[1] = '{8,  1'b1, 0, 1'b0, 1'b0, 5'd1};
    vecs[2] = '{9,  1'b0, 0, 1'b0, 1'b0, 5'd0};
    vecs[3] = '{10, 1'b0, 0, 1'b0, 1'b1, 5'd0};
    vecs[4] = '{2,  1'b1, 1, 1'b0, 1'b1, 5'd0};
    vecs[5] = '{0,  1'b1, 2, 1'b0, 1'b1, 5'd0};
    vecs[6] = '{1,  1'b1, 3, 1'b0, 1'b1, 5'd0};
    vecs[7] = '{0,  1'b1, 1, 1'b1, 1'b1, 5'd0};
    vecs[8] = '{0,  1'b1, 0, 1'b1, 1'b0, 5'd1};

    // Reset state
    do_reset();
    mon_en = 1'b1;
    check("rst_outputs", {rf_we, rf_wdata, rf_wsel, rf_rsel, lamp, level, busy, win, lose},
          32'h0);

    // First round and full game to 16
    start_game();
    for (int r = 1; r <= 16; r++) begin
      play_round(0);
      echo_round();
    end
    check("win_final", win, 1'b1);
    check("level_final", level, 5'd16);
    check("all_indices_written", wr_mask, 16'hFFFF);
    step();
    check("win_hold", {win, busy, level}, {1'b1, 1'b0, 5'd16});

    // WAIT_IN reaction table, round 1
    for (int v = 0; v < 9; v++) begin
      do_reset();
      start_game();
      play_round(0);
      repeat (vecs[v].idle) step();
      if (vecs[v].press) begin
        case (vecs[v].kind)
          0: b = seq[0];
          1: b = rot(seq[0]);
          2: b = 4'b0011;
          default: b = 4'b0000;
        endcase
        if (vecs[v].kind == 0) expect_add();
        start = vecs[v].with_start;
        press(b);
        start = 1'b0;
      end
      check("tbl_lose", lose, vecs[v].exp_lose);
      check("tbl_level", level, vecs[v].exp_level);
      check("tbl_busy", busy, !vecs[v].exp_lose);
    end

    // Wrong button mid-sequence in round 3
    do_reset();
    start_game();
    for (int r = 1; r <= 2; r++) begin
      play_round(0);
      echo_round();
    end
    play_round(0);
    press(seq[0]);
    press(rot(seq[1]));
    check("r3_lose", lose, 1'b1);
    check("r3_level", level, 5'd2);
    repeat (4) step();
    check("r3_no_more_writes", exp_q.size(), 0);
    check("r3_lose_hold", {lose, busy}, 2'b10);

    // Timeout timer reloads on each accepted press
    do_reset();
    start_game();
    play_round(0);
    echo_round();
    play_round(0);
    repeat (8) step();
    press(seq[0]);
    repeat (8) step();
    check("reload_no_lose", lose, 1'b0);
    expect_add();
    press(seq[1]);
    check("reload_level", level, 5'd2);

    // Reset during SHOW_ON of round 2
    do_reset();
    start_game();
    play_round(0);
    echo_round();
    step();
    check("r2_lamp_on", lamp, seq[0]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    len_m = 0;
    check("midrst_outputs", {lamp, level, busy, win, lose, rf_we}, 32'h0);

    // start during SHOW_OFF ignored; btn_valid during SHOW_ON ignored
    start_game();
    play_round(1);
    echo_round();
    play_round(2);
    echo_round();
    check("ignored_inputs_level", level, 5'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_seq_ctrl.md
GAME_SEQ_CTRL -- requirements
Module: game_seq_ctrl

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 25_000_000, cycles each lamp is on and each following gap is off during playback.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 125_000_000, maximum cycles allowed between player inputs.
REQ-003 SHALL have ports:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse, begin or restart a game
btn_valid  in  1  single-cycle pulse, player pressed a button
btn  in  4  one-hot button code, valid with btn_valid
rf_we  out  1  register-file write enable
rf_wdata  out  4  register-file write data
rf_wsel  out  4  register-file write index
rf_rsel  out  4  register-file read index
rf_rdata  in  4  register-file read data, combinational from rf_rsel
lamp  out  4  one-hot lamp drive, 0 = all off
level  out  5  completed sequence length, 0..16
busy  out  1  game in progress (ADD, SHOW_ON, SHOW_OFF, WAIT_IN)
win  out  1  high in WIN
lose  out  1  high in LOSE

Function
REQ-004 SHALL implement states IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE.
REQ-005 IDLE/WIN/LOSE: start SHALL clear len and idx and enter ADD; other inputs ignored.
REQ-006 ADD (one cycle): SHALL assert rf_we with rf_wsel=len[3:0], rf_wdata=onehot(lfsr[1:0]); len<=len+1, idx<=0, load timer, enter SHOW_ON.
REQ-007 SHOW_ON: rf_rsel=idx, lamp=rf_rdata for exactly SHOW_CYCLES cycles, then SHOW_OFF with timer reloaded.
REQ-008 SHOW_OFF: lamp=0 for exactly SHOW_CYCLES cycles; then if idx==len-1 -> WAIT_IN with idx=0 and timeout timer loaded, else idx++ -> SHOW_ON.
REQ-009 WAIT_IN: rf_rsel=idx, lamp=0; on btn_valid, btn==rf_rdata and idx<len-1 -> idx++, timeout reloaded.
REQ-010 WAIT_IN: on btn_valid with match at idx==len-1 -> level<=len; then WIN if len==16, else ADD.
REQ-011 WAIT_IN: btn_valid with btn!=rf_rdata (including non-one-hot btn) -> LOSE next cycle.
REQ-012 WAIT_IN: TIMEOUT_CYCLES cycles without btn_valid -> LOSE.
REQ-013 btn_valid outside WAIT_IN SHALL be ignored; start outside IDLE/WIN/LOSE SHALL be ignored; start and btn_valid in same WAIT_IN cycle: btn processed, start ignored.
REQ-014 rf_we SHALL be high only in ADD; rf_wdata/rf_wsel SHALL be 0 otherwise.
REQ-015 len SHALL be 5-bit, saturate at 16 (never wraps); rf_wsel uses len[3:0], so index 15 is the last write.
REQ-016 level SHALL hold its value through WIN/LOSE and clear on start.
REQ-017 LFSR SHALL be 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle after reset regardless of state, so sequence depends on player timing.
REQ-018 All outputs SHALL be registered or decoded from state only; no combinational path btn->lamp.

Reset
REQ-019 rst SHALL force state IDLE, len=0, idx=0, timers=0, lfsr=16'hACE1, all outputs 0, taking priority over all inputs, including mid-playback and mid-input.
REQ-020 Register-file contents SHALL NOT be cleared; every entry is written before read.

Structure
REQ-021 game_pkg SHALL hold the state enum, MAX_LEN=16, LFSR_SEED=16'hACE1, LFSR tap mask 16'hB400.
REQ-022 LFSR SHALL be sub-module lfsr16 (clk, rst, q[15:0]); timers and FSM stay in game_seq_ctrl.

Verification (SHOW_CYCLES=2, TIMEOUT_CYCLES=10, reg_file attached)
REQ-023 rst then start -> one cycle rf_we=1, rf_wsel=0, rf_wdata=onehot(lfsr[1:0]); lamp equals that code 2 cycles, 0 for 2 cycles; then WAIT_IN, busy=1.
REQ-024 Correct echo of each round through len=16 -> level steps 1..16, win=1, busy=0; 16 distinct write indices 0..15.
REQ-025 Round 3, wrong btn at idx 1 -> lose=1 next cycle, level=2, no further rf_we.
REQ-026 WAIT_IN idle 10 cycles -> lose=1; btn_valid at cycle 9 instead -> accepted, timer reloaded.
REQ-027 rst asserted during SHOW_ON -> next cycle IDLE, lamp=0, level=0; start during SHOW_OFF -> ignored, playback timing unchanged.
REQ-028 btn=4'b0011 with btn_valid in WAIT_IN -> LOSE; btn_valid during SHOW_ON -> no effect.
